div_sequencer: RTL
==================

# div_sequencer

Multi-cycle divide unit and pipeline-stall sequencer for the EX stage. It accepts a decoded div/divu issue, runs a 32-iteration restoring shift-subtract division, and holds the pipeline via `stall` until the result is ready. It then presents quotient and remainder for one cycle, for the LO and HI writes gated by `hilo_we`. It resolves divide-by-zero early and supports cancellation of an in-flight operation on pipeline flush.

## Interface
- No parameters; data width fixed at 32.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  EX-stage instruction is div/divu (decoder `isDiv` qualified by EX valid). Sampled only in IDLE.
- `signed_div`  in  1  1 = div (signed), 0 = divu. Sampled with `start`.
- `a`  in  32  dividend (rs value). Sampled with `start`.
- `b`  in  32  divisor (rt value). Sampled with `start`.
- `annul`  in  1  flush or exception; cancels any operation in flight.
- `stall`  out  1  combinational; holds IF/ID/EX while the divide is pending.
- `result_valid`  out  1  registered one-cycle pulse; result is ready this cycle.
- `quotient`  out  32  destined for LO; holds its value between results.
- `remainder`  out  32  destined for HI; holds its value between results.

## Operation
- **States:** IDLE, BUSY, DONE.
- **IDLE, `start`=1, `annul`=0, `b`≠0:**
  - Latch |a| and |b|, using two's-complement magnitude when `signed_div`=1, raw values otherwise.
  - Latch `q_neg` = a[31]^b[31] and `r_neg` = a[31]; both are forced to 0 for divu.
  - Clear the 32-bit partial remainder, load the dividend shift register, set the 5-bit counter to 0, and go to BUSY.
- **IDLE, `start`=1, `b`=0:** go directly to DONE and load `quotient`=0xFFFFFFFF, `remainder`=a. Applies to both signed and unsigned.
- **BUSY, each cycle:**
  - Shift {rem, dividend} left by 1 and compute trial = rem_shifted − |b| at 33 bits.
  - If trial is non-negative, rem = trial[31:0] and the quotient LSB is 1; otherwise the LSB is 0.
  - Increment the counter. When the counter reaches 31 (the 32nd iteration), go to DONE.
- **BUSY→DONE sign fix-up:** `quotient` = q_neg ? −q : q and `remainder` = r_neg ? −r : r, at 32-bit wrap.
  - 0x80000000 / 0xFFFFFFFF (signed) yields quotient 0x80000000, remainder 0, with no trap.
- **DONE:** `result_valid`=1 and `stall`=0, so the instruction leaves EX at the end of this cycle. Return to IDLE unconditionally. `start` is ignored in DONE.
- **`stall`** = ~annul & ((IDLE & start) | BUSY).
- **`annul`** has priority over everything:
  - From any state, the next state is IDLE and `result_valid` stays 0 for that operation.
  - `quotient`/`remainder` keep their previous values.
  - In the annul cycle itself, `start` is ignored.
- **`rst`:** state IDLE, counter 0, `quotient`=0, `remainder`=0, `result_valid`=0. `stall` is 0 from the first cycle after reset unless `start` is asserted.

## Timing
- Normal divide: `start` seen in cycle 0, BUSY in cycles 1–32, DONE in cycle 33.
  - `stall` is high in cycles 0–32 (33 cycles) and low in cycle 33.
  - `result_valid` is high only in cycle 33; `quotient`/`remainder` are valid from cycle 33 and hold afterwards.
- Divide-by-zero: `stall` high in cycle 0 only, DONE and `result_valid` in cycle 1.
- Back-to-back: a new `start` is accepted no earlier than the IDLE cycle after DONE (cycle 34). There is no accept-in-DONE path.
- `a`, `b` and `signed_div` may change after cycle 0 without affecting the operation.
- Reset mid-operation (BUSY): IDLE next cycle, with no `result_valid` and no stale output.

## Test plan
- **divu 100/7:** `start` cycle 0 → `stall` high for 33 cycles, `result_valid` in cycle 33, quotient 14, remainder 2.
- **Signed edge cases:**
  - div −7/2 (a=0xFFFFFFF9, b=2) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
  - div 0x80000000/0xFFFFFFFF → quotient 0x80000000, remainder 0.
  - divu 0xFFFFFFFF/1 → quotient 0xFFFFFFFF, remainder 0.
- **Divide by zero:** a=0x12345678, b=0 → `result_valid` in cycle 1, quotient 0xFFFFFFFF, remainder 0x12345678, `stall` high 1 cycle.
- **Annul:** `annul` at cycle 10 of BUSY → `stall` low that cycle, IDLE next cycle, no `result_valid`, outputs unchanged. A `start` of divu 9/3 on the following cycle → quotient 3, remainder 0 after 33 cycles.
- **Reset mid-op:** `rst` at cycle 20 → IDLE, `quotient`=`remainder`=0, `result_valid` never pulses.
- **Back-to-back:** divu 50/5 immediately followed by div −50/5 → second `start` accepted at cycle 34, results (10,0) then (0xFFFFFFF6,0), one `result_valid` pulse each.

Source files
------------

// File: rtl/div_sequencer.sv
// EX-stage divide unit: 32-iteration restoring shift-subtract divider that
// stalls the pipeline while busy and pulses result_valid for the LO/HI write.
module div_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        annul,
  output logic        stall,
  output logic        result_valid,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  // state | meaning
  // IDLE  | waiting for a div/divu issue
  // BUSY  | one shift-subtract iteration per cycle, 32 cycles
  // DONE  | result presented for one cycle, pipeline released
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [31:0] rem_q;
  logic [31:0] dvd_q;
  logic [31:0] dsr_q;
  logic        q_neg;
  logic        r_neg;

  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] rem_sh;
  logic        q_bit;
  logic [31:0] rem_next;
  logic [31:0] quo_next;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  assign abs_a = (signed_div && a[31]) ? (~a + 32'd1) : a;
  assign abs_b = (signed_div && b[31]) ? (~b + 32'd1) : b;

  // Partial remainder is kept at 33 bits after the shift so that unsigned
  // divisors with bit 31 set still compare correctly.
  always_comb begin
    rem_sh   = {rem_q, dvd_q[31]};
    q_bit    = (rem_sh >= {1'b0, dsr_q});
    rem_next = q_bit ? (rem_sh[31:0] - dsr_q) : rem_sh[31:0];
    quo_next = {dvd_q[30:0], q_bit};
    q_fix    = q_neg ? (~quo_next + 32'd1) : quo_next;
    r_fix    = r_neg ? (~rem_next + 32'd1) : rem_next;
  end

  assign stall = ~annul & (((state == IDLE) & start) | (state == BUSY));

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 5'd0;
      rem_q        <= 32'd0;
      dvd_q        <= 32'd0;
      dsr_q        <= 32'd0;
      q_neg        <= 1'b0;
      r_neg        <= 1'b0;
      quotient     <= 32'd0;
      remainder    <= 32'd0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (annul) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (b == 32'd0) begin
                state        <= DONE;
                quotient     <= 32'hFFFF_FFFF;
                remainder    <= a;
                result_valid <= 1'b1;
              end else begin
                dvd_q <= abs_a;
                dsr_q <= abs_b;
                rem_q <= 32'd0;
                cnt   <= 5'd0;
                q_neg <= signed_div & (a[31] ^ b[31]);
                r_neg <= signed_div & a[31];
                state <= BUSY;
              end
            end
          end
          BUSY: begin
            rem_q <= rem_next;
            dvd_q <= quo_next;
            cnt   <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              state        <= DONE;
              quotient     <= q_fix;
              remainder    <= r_fix;
              result_valid <= 1'b1;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
